// File: rtl/cp0_regfile.sv
// MIPS-style CP0 register file: Status/Cause/EPC/BadVAddr, exception entry and ERET redirect.
// Optional Count/Compare timer is compiled in when CP0_TIMER_INT_EN is defined.
module cp0_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr,
    output logic [31:0] rdata,
    input  logic [5:0]  int_i,
    input  logic [31:0] exception_type,
    input  logic [31:0] current_pc,
    input  logic        in_delay_slot,
    input  logic [31:0] bad_addr,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        timer_int_o
);

    localparam logic [31:0] EXC_INT        = 32'h1;
    localparam logic [31:0] EXC_INST_ADDR  = 32'h4;
    localparam logic [31:0] EXC_DATA_ADDRL = 32'h5;
    localparam logic [31:0] EXC_DATA_ADDRS = 32'h6;
    localparam logic [31:0] EXC_SYSCALL    = 32'h8;
    localparam logic [31:0] EXC_BREAK      = 32'h9;
    localparam logic [31:0] EXC_RI         = 32'ha;
    localparam logic [31:0] EXC_OVF        = 32'hc;
    localparam logic [31:0] EXC_ERET       = 32'he;
    localparam logic [31:0] EXC_VECTOR     = 32'hBFC0_0380;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    logic [7:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip_hw;
    logic [1:0]  r_ip_sw;
    logic [4:0]  r_exccode;
    logic [31:0] r_epc;
    logic [31:0] r_badvaddr;

    logic        w_is_exc;
    logic        w_is_eret;
    logic        w_mtc0;
    logic [4:0]  w_exccode;
    logic        w_ti;
    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic [31:0] w_status;
    logic [31:0] w_cause;

    always_comb begin
        w_is_exc  = 1'b1;
        w_exccode = 5'd0;
        case (exception_type)
            EXC_INT:        w_exccode = 5'd0;
            EXC_INST_ADDR:  w_exccode = 5'd4;
            EXC_DATA_ADDRL: w_exccode = 5'd4;
            EXC_DATA_ADDRS: w_exccode = 5'd5;
            EXC_SYSCALL:    w_exccode = 5'd8;
            EXC_BREAK:      w_exccode = 5'd9;
            EXC_RI:         w_exccode = 5'd10;
            EXC_OVF:        w_exccode = 5'd12;
            default:        w_is_exc  = 1'b0;
        endcase
    end

    assign w_is_eret = (exception_type == EXC_ERET);
    // Any committed exception or ERET in the same cycle swallows the MTC0.
    assign w_mtc0    = we && !w_is_exc && !w_is_eret;

`ifdef CP0_TIMER_INT_EN
    logic        r_tick;
    logic        r_ti;
    logic [31:0] r_count;
    logic [31:0] r_compare;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick    <= 1'b0;
            r_ti      <= 1'b0;
            r_count   <= 32'h0;
            r_compare <= 32'h0;
        end else begin
            r_tick <= ~r_tick;
            if (w_mtc0 && waddr == REG_COUNT)
                r_count <= wdata;
            else if (r_tick)
                r_count <= r_count + 32'd1;
            if (w_mtc0 && waddr == REG_COMPARE) begin
                r_compare <= wdata;
                r_ti      <= 1'b0;
            end else if (r_count == r_compare) begin
                r_ti <= 1'b1;
            end
        end
    end

    assign w_ti      = r_ti;
    assign w_count   = r_count;
    assign w_compare = r_compare;
`else
    assign w_ti      = 1'b0;
    assign w_count   = 32'h0;
    assign w_compare = 32'h0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_im       <= 8'h0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_bd       <= 1'b0;
            r_ip_hw    <= 6'h0;
            r_ip_sw    <= 2'h0;
            r_exccode  <= 5'h0;
            r_epc      <= 32'h0;
            r_badvaddr <= 32'h0;
        end else begin
            r_ip_hw <= {int_i[5] | w_ti, int_i[4:0]};
            if (w_is_exc) begin
                r_exl     <= 1'b1;
                r_exccode <= w_exccode;
                // Nested exceptions keep the original return point.
                if (!r_exl) begin
                    r_epc <= in_delay_slot ? current_pc - 32'd4 : current_pc;
                    r_bd  <= in_delay_slot;
                end
                if (exception_type == EXC_INST_ADDR)
                    r_badvaddr <= current_pc;
                else if (exception_type == EXC_DATA_ADDRL || exception_type == EXC_DATA_ADDRS)
                    r_badvaddr <= bad_addr;
            end else if (w_is_eret) begin
                r_exl <= 1'b0;
            end else if (w_mtc0) begin
                case (waddr)
                    REG_STATUS: begin
                        r_im  <= wdata[15:8];
                        r_exl <= wdata[1];
                        r_ie  <= wdata[0];
                    end
                    REG_CAUSE: r_ip_sw <= wdata[9:8];
                    REG_EPC:   r_epc   <= wdata;
                    default: ;
                endcase
            end
        end
    end

    // Bit 22 (BEV) is hardwired to 1.
    assign w_status = {9'h0, 1'b1, 6'h0, r_im, 6'h0, r_exl, r_ie};
    assign w_cause  = {r_bd, w_ti, 14'h0, r_ip_hw, r_ip_sw, 1'b0, r_exccode, 2'b00};

    always_comb begin
        rdata = 32'h0;
        case (raddr)
            REG_BADVADDR: rdata = r_badvaddr;
            REG_COUNT:    rdata = w_count;
            REG_COMPARE:  rdata = w_compare;
            REG_STATUS:   rdata = w_status;
            REG_CAUSE:    rdata = w_cause;
            REG_EPC:      rdata = r_epc;
            default:      rdata = 32'h0;
        endcase
    end

    always_comb begin
        flush  = 1'b0;
        new_pc = 32'h0;
        if (w_is_exc) begin
            flush  = 1'b1;
            new_pc = EXC_VECTOR;
        end else if (w_is_eret) begin
            flush  = 1'b1;
            new_pc = r_epc;
        end
    end

    assign status_o    = w_status;
    assign cause_o     = w_cause;
    assign epc_o       = r_epc;
    assign timer_int_o = w_ti;

endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: directed vector table, timer sequence, and
// randomized traffic against a behavioural model of the CP0 registers.
module tb_cp0_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    logic [5:0]  int_i;
    logic [31:0] exception_type;
    logic [31:0] current_pc;
    logic        in_delay_slot;
    logic [31:0] bad_addr;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic        flush;
    logic [31:0] new_pc;
    logic        timer_int_o;

    cp0_regfile dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
        .rdata(rdata), .int_i(int_i), .exception_type(exception_type),
        .current_pc(current_pc), .in_delay_slot(in_delay_slot), .bad_addr(bad_addr),
        .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o), .flush(flush),
        .new_pc(new_pc), .timer_int_o(timer_int_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: architectural register images.
    logic [31:0] m_status, m_cause, m_epc, m_badv, m_count, m_compare;
    logic        m_ti;
    int          m_edges;

    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Returns ExcCode, -2 for ERET, -1 for anything treated as no exception.
    function automatic int exc_code(input logic [31:0] t);
        case (t)
            32'h1: return 0;
            32'h4: return 4;
            32'h5: return 4;
            32'h6: return 5;
            32'h8: return 8;
            32'h9: return 9;
            32'ha: return 10;
            32'hc: return 12;
            32'he: return -2;
            default: return -1;
        endcase
    endfunction

    function automatic logic [31:0] m_cause_img();
        logic [31:0] c;
        c = m_cause;
        c[30] = m_ti;
        return c;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] ra);
        case (ra)
            5'd8:  return m_badv;
            5'd9:  return m_count;
            5'd11: return m_compare;
            5'd12: return m_status;
            5'd13: return m_cause_img();
            5'd14: return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    function automatic void model_reset();
        m_status = 32'h0040_0000;
        m_cause = 0; m_epc = 0; m_badv = 0; m_count = 0; m_compare = 0;
        m_ti = 1'b0; m_edges = 0;
    endfunction

    function automatic void model_edge();
        int c;
        logic [31:0] ns, nc, ne, nb, ncnt, ncmp;
        logic nti;
        c = exc_code(exception_type);
        ns = m_status; nc = m_cause; ne = m_epc; nb = m_badv;
        ncnt = m_count; ncmp = m_compare; nti = m_ti;
        nc[15:10] = {int_i[5] | m_ti, int_i[4:0]};
        if (c >= 0) begin
            ns[1] = 1'b1;
            nc[6:2] = c[4:0];
            if (!m_status[1]) begin
                ne = in_delay_slot ? current_pc - 32'd4 : current_pc;
                nc[31] = in_delay_slot;
            end
            if (exception_type == 32'h4) nb = current_pc;
            else if (exception_type == 32'h5 || exception_type == 32'h6) nb = bad_addr;
        end else if (c == -2) begin
            ns[1] = 1'b0;
        end else if (we) begin
            case (waddr)
                5'd12: ns = (m_status & ~STATUS_WMASK) | (wdata & STATUS_WMASK);
                5'd13: nc[9:8] = wdata[9:8];
                5'd14: ne = wdata;
                default: ;
            endcase
        end
`ifdef CP0_TIMER_INT_EN
        if (m_edges % 2 == 1) ncnt = m_count + 32'd1;
        if (c == -1 && we && waddr == 5'd9) ncnt = wdata;
        if (c == -1 && we && waddr == 5'd11) begin
            ncmp = wdata;
            nti = 1'b0;
        end else if (m_count == m_compare) begin
            nti = 1'b1;
        end
`endif
        m_status = ns; m_cause = nc; m_epc = ne; m_badv = nb;
        m_count = ncnt; m_compare = ncmp; m_ti = nti;
        m_edges++;
    endfunction

    task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra, input logic [31:0] ex, input logic [31:0] pc,
                         input logic ds, input logic [31:0] ba, input logic [5:0] ii);
        we = w; waddr = wa; wdata = wd; raddr = ra; exception_type = ex;
        current_pc = pc; in_delay_slot = ds; bad_addr = ba; int_i = ii;
    endtask

    task automatic idle(input logic [4:0] ra);
        drive(1'b0, 5'd0, 32'h0, ra, 32'h0, 32'h0, 1'b0, 32'h0, 6'h0);
    endtask

    task automatic check_model();
        int c;
        c = exc_code(exception_type);
        chk("flush", {31'h0, flush}, {31'h0, c != -1});
        chk("new_pc", new_pc, (c >= 0) ? 32'hBFC0_0380 : (c == -2) ? m_epc : 32'h0);
        chk("rdata", rdata, m_read(raddr));
        chk("status_o", status_o, m_status);
        chk("cause_o", cause_o, m_cause_img());
        chk("epc_o", epc_o, m_epc);
        chk("timer_int_o", {31'h0, timer_int_o}, {31'h0, m_ti});
    endtask

    task automatic clock_edge();
        @(posedge clk);
        if (rst) model_reset(); else model_edge();
        #1;
    endtask

    task automatic cyc();
        @(negedge clk);
        check_model();
        clock_edge();
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra;
        logic [31:0] ex;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] ba;
        logic [31:0] exp_rdata;
        logic [31:0] rmask;
        logic        exp_flush;
        logic [31:0] exp_npc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                                input logic [4:0] ra, input logic [31:0] ex, input logic [31:0] pc,
                                input logic ds, input logic [31:0] ba, input logic [31:0] er,
                                input logic [31:0] em, input logic ef, input logic [31:0] enp);
        vec_t v;
        v.we = w; v.wa = wa; v.wd = wd; v.ra = ra; v.ex = ex; v.pc = pc; v.ds = ds; v.ba = ba;
        v.exp_rdata = er; v.rmask = em; v.exp_flush = ef; v.exp_npc = enp;
        return v;
    endfunction

    localparam logic [31:0] ALL = 32'hFFFF_FFFF;
    // Cause reads ignore TI and the TI-fed hardware pending bit.
    localparam logic [31:0] CMASK = 32'hBFFF_7FFF;
    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic [31:0] exc_pool [10];
    logic [4:0]  wa_pool [7];

    initial begin
        int waited;
        int r;
        exc_pool = '{32'h1, 32'h4, 32'h5, 32'h6, 32'h8, 32'h9, 32'ha, 32'hc, 32'he, 32'h7};
        wa_pool  = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};

        tbl.push_back(mk(0, 0, 0, 12, 32'h0, 0, 0, 0, 32'h0040_0000, ALL, 0, 0));
        tbl.push_back(mk(0, 0, 0, 13, 32'h0, 0, 0, 0, 32'h0, CMASK, 0, 0));
        tbl.push_back(mk(0, 0, 0, 12, 32'h8, 32'hBFC0_1000, 1, 0, 32'h0040_0000, ALL, 1, VEC));
        tbl.push_back(mk(0, 0, 0, 14, 32'h0, 0, 0, 0, 32'hBFC0_0FFC, ALL, 0, 0));
        tbl.push_back(mk(0, 0, 0, 13, 32'h0, 0, 0, 0, 32'h8000_0020, CMASK, 0, 0));
        tbl.push_back(mk(0, 0, 0, 12, 32'h0, 0, 0, 0, 32'h0040_0002, ALL, 0, 0));
        tbl.push_back(mk(0, 0, 0, 14, 32'hc, 32'h8000_0010, 0, 0, 32'hBFC0_0FFC, ALL, 1, VEC));
        tbl.push_back(mk(0, 0, 0, 14, 32'h0, 0, 0, 0, 32'hBFC0_0FFC, ALL, 0, 0));
        tbl.push_back(mk(0, 0, 0, 13, 32'h0, 0, 0, 0, 32'h8000_0030, CMASK, 0, 0));
        tbl.push_back(mk(0, 0, 0, 12, 32'he, 0, 0, 0, 32'h0040_0002, ALL, 1, 32'hBFC0_0FFC));
        tbl.push_back(mk(0, 0, 0, 12, 32'h0, 0, 0, 0, 32'h0040_0000, ALL, 0, 0));
        tbl.push_back(mk(1, 14, 32'h1234_5678, 8, 32'h6, 32'h8000_0100, 0, 32'h8000_0003,
                         32'h0, ALL, 1, VEC));
        tbl.push_back(mk(0, 0, 0, 8, 32'h0, 0, 0, 0, 32'h8000_0003, ALL, 0, 0));
        tbl.push_back(mk(0, 0, 0, 14, 32'h0, 0, 0, 0, 32'h8000_0100, ALL, 0, 0));
        tbl.push_back(mk(0, 0, 0, 13, 32'h0, 0, 0, 0, 32'h0000_0014, CMASK, 0, 0));
        tbl.push_back(mk(1, 12, ALL, 12, 32'h0, 0, 0, 0, 32'h0040_0002, ALL, 0, 0));
        tbl.push_back(mk(0, 0, 0, 12, 32'h0, 0, 0, 0, 32'h0040_FF03, ALL, 0, 0));
        tbl.push_back(mk(1, 12, 32'h0, 12, 32'h0, 0, 0, 0, 32'h0040_FF03, ALL, 0, 0));
        tbl.push_back(mk(1, 8, 32'h0, 12, 32'h0, 0, 0, 0, 32'h0040_0000, ALL, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8, 32'h0, 0, 0, 0, 32'h8000_0003, ALL, 0, 0));
        tbl.push_back(mk(0, 0, 0, 3, 32'h0, 0, 0, 0, 32'h0, ALL, 0, 0));
        tbl.push_back(mk(1, 13, ALL, 13, 32'h0, 0, 0, 0, 32'h0000_0014, CMASK, 0, 0));
        tbl.push_back(mk(0, 0, 0, 13, 32'h0, 0, 0, 0, 32'h0000_0314, CMASK, 0, 0));
        tbl.push_back(mk(0, 0, 0, 14, 32'h4, 32'h8000_0204, 0, 32'hDEAD_BEEF,
                         32'h8000_0100, ALL, 1, VEC));
        tbl.push_back(mk(0, 0, 0, 8, 32'h0, 0, 0, 0, 32'h8000_0204, ALL, 0, 0));
        tbl.push_back(mk(0, 0, 0, 14, 32'h0, 0, 0, 0, 32'h8000_0204, ALL, 0, 0));
        tbl.push_back(mk(0, 0, 0, 13, 32'h0, 0, 0, 0, 32'h0000_0310, CMASK, 0, 0));

        // Reset; second reset cycle also proves flush/new_pc stay live under rst.
        rst = 1'b1;
        idle(5'd0);
        @(posedge clk); #1;
        drive(1'b1, 5'd14, 32'h5555_5555, 5'd0, 32'h8, 32'h1234_0000, 1'b0, 32'h0, 6'h0);
        @(negedge clk);
        chk("rst_flush", {31'h0, flush}, 32'h1);
        chk("rst_new_pc", new_pc, VEC);
        clock_edge();
        rst = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ra, tbl[i].ex, tbl[i].pc,
                  tbl[i].ds, tbl[i].ba, 6'h0);
            @(negedge clk);
            check_model();
            chk($sformatf("tbl%0d.flush", i), {31'h0, flush}, {31'h0, tbl[i].exp_flush});
            chk($sformatf("tbl%0d.new_pc", i), new_pc, tbl[i].exp_npc);
            chk($sformatf("tbl%0d.rdata", i), rdata & tbl[i].rmask, tbl[i].exp_rdata & tbl[i].rmask);
            clock_edge();
        end

`ifdef CP0_TIMER_INT_EN
        drive(1'b1, 5'd9, 32'h0, 5'd9, 32'h0, 0, 0, 0, 6'h0);
        cyc();
        drive(1'b1, 5'd11, 32'd5, 5'd11, 32'h0, 0, 0, 0, 6'h0);
        cyc();
        chk("ti_cleared", {31'h0, timer_int_o}, 32'h0);
        idle(5'd9);
        waited = 0;
        while (!timer_int_o && waited < 40) begin
            cyc();
            waited++;
        end
        chk("ti_set", {31'h0, timer_int_o}, 32'h1);
        chk("ti_latency_ok", {31'h0, (waited >= 6 && waited <= 14)}, 32'h1);
        cyc();
        chk("cause_ip7", {31'h0, cause_o[15]}, 32'h1);
        chk("cause_ti", {31'h0, cause_o[30]}, 32'h1);
        drive(1'b1, 5'd11, 32'd100, 5'd11, 32'h0, 0, 0, 0, 6'h0);
        cyc();
        chk("ti_clr_cmp100", {31'h0, timer_int_o}, 32'h0);
`else
        drive(1'b1, 5'd11, 32'd5, 5'd11, 32'h0, 0, 0, 0, 6'h0);
        cyc();
        drive(1'b1, 5'd9, 32'd5, 5'd9, 32'h0, 0, 0, 0, 6'h0);
        cyc();
        idle(5'd9);
        for (int k = 0; k < 20; k++) begin
            cyc();
            chk("no_timer_int", {31'h0, timer_int_o}, 32'h0);
        end
        chk("count_absent", rdata, 32'h0);
`endif

        // Randomized traffic checked against the model every cycle.
        for (int k = 0; k < 500; k++) begin
            logic [31:0] ex, wd;
            r = $urandom_range(0, 9);
            ex = (r < 6) ? 32'h0 : exc_pool[$urandom_range(0, 9)];
            wd = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            drive(1'($urandom_range(0, 1)), wa_pool[$urandom_range(0, 6)], wd,
                  5'($urandom_range(0, 31)), ex, $urandom, 1'($urandom_range(0, 1)),
                  $urandom, 6'($urandom));
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
